// File: rtl/dcache_responder.sv
// Direct-mapped, write-through, no-write-allocate data cache responder for the core data port.
// Build with DCACHE_STATS_EN defined to add the hit_count / miss_count outputs.
module dcache_responder #(
   parameter int LINES      = 64,
   parameter int LINE_WORDS = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] dcache_addr,
   input  logic        dcache_re,
   input  logic [3:0]  dcache_we,
   input  logic [31:0] dcache_din,
   output logic [31:0] dcache_dout,
   output logic        stall,
   output logic        mem_req_valid,
   input  logic        mem_req_ready,
   output logic        mem_req_rnw,
   output logic [31:0] mem_req_addr,
   output logic [31:0] mem_req_data,
   output logic [3:0]  mem_req_mask,
   input  logic        mem_resp_valid,
   input  logic [31:0] mem_resp_data
`ifdef DCACHE_STATS_EN
   ,
   output logic [31:0] hit_count,
   output logic [31:0] miss_count
`endif
);

   localparam int WB   = $clog2(LINE_WORDS);
   localparam int IB   = $clog2(LINES);
   localparam int TAGB = 30 - WB - IB;
   localparam int PB   = IB + WB;

   typedef enum logic [1:0] {IDLE, FILL_REQ, FILL_WAIT, WR_REQ} state_t;

   logic [WB-1:0]   word;
   logic [IB-1:0]   idx;
   logic [TAGB-1:0] tag;
   logic            unused_addr_bits;

   assign word             = dcache_addr[2 +: WB];
   assign idx              = dcache_addr[2+WB +: IB];
   assign tag              = dcache_addr[31 -: TAGB];
   assign unused_addr_bits = ^dcache_addr[1:0];

   logic [31:0]      data_mem [LINES*LINE_WORDS];
   logic [TAGB-1:0]  tag_mem  [LINES];
   logic [LINES-1:0] valid_q, valid_d;

   state_t        state_q, state_d;
   logic [WB-1:0] cnt_q, cnt_d, cnt_nxt;
   logic          stall_q, stall_d;
   logic [31:0]   dout_q, dout_d;
   logic          req_valid_q, req_valid_d;
   logic          rnw_q, rnw_d;
   logic [31:0]   addr_q, addr_d;
   logic [31:0]   data_q, data_d;
   logic [3:0]    mask_q, mask_d;

   logic          hit;
   logic [31:0]   rd_word;
   logic          arr_we;
   logic [PB-1:0] arr_ptr;
   logic [31:0]   arr_wdata;
   logic          tag_we;

   assign hit     = valid_q[idx] && (tag_mem[idx] == tag);
   assign rd_word = data_mem[{idx, word}];
   assign cnt_nxt = cnt_q + 1'b1;

   function automatic logic [31:0] merge_bytes(input logic [31:0] old_w, input logic [31:0] new_w,
                                               input logic [3:0] be);
      logic [31:0] r;
      r = old_w;
      for (int i = 0; i < 4; i++) begin
         if (be[i]) r[8*i +: 8] = new_w[8*i +: 8];
      end
      return r;
   endfunction

   // Backing-memory handshake: a request transfers on a cycle where mem_req_valid && mem_req_ready;
   // while valid is high and ready low, every mem_req_* field holds. Reads get exactly one
   // in-order mem_resp_valid each, writes are posted with no response.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      valid_d     = valid_q;
      stall_d     = stall_q;
      dout_d      = dout_q;
      req_valid_d = req_valid_q;
      rnw_d       = rnw_q;
      addr_d      = addr_q;
      data_d      = data_q;
      mask_d      = mask_q;
      arr_we      = 1'b0;
      arr_ptr     = {idx, word};
      arr_wdata   = merge_bytes(rd_word, dcache_din, dcache_we);
      tag_we      = 1'b0;
      case (state_q)
         IDLE: begin
            if (dcache_we != 4'b0000) begin
               // Hits are merged here so a following read of the same word is coherent.
               arr_we      = hit;
               stall_d     = 1'b1;
               state_d     = WR_REQ;
               req_valid_d = 1'b1;
               rnw_d       = 1'b0;
               addr_d      = {dcache_addr[31:2], 2'b00};
               data_d      = dcache_din;
               mask_d      = dcache_we;
            end else if (dcache_re) begin
               if (hit) begin
                  dout_d = rd_word;
               end else begin
                  valid_d[idx] = 1'b0;
                  cnt_d        = '0;
                  stall_d      = 1'b1;
                  state_d      = FILL_REQ;
                  req_valid_d  = 1'b1;
                  rnw_d        = 1'b1;
                  addr_d       = {tag, idx, {WB{1'b0}}, 2'b00};
               end
            end
         end
         FILL_REQ: begin
            if (mem_req_ready) begin
               req_valid_d = 1'b0;
               state_d     = FILL_WAIT;
            end
         end
         FILL_WAIT: begin
            if (mem_resp_valid) begin
               arr_we    = 1'b1;
               arr_ptr   = {idx, cnt_q};
               arr_wdata = mem_resp_data;
               cnt_d     = cnt_nxt;
               if (&cnt_q) begin
                  // The last word lands in the array on this same edge, so take it from the write port.
                  tag_we       = 1'b1;
                  valid_d[idx] = 1'b1;
                  dout_d       = (cnt_q == word) ? mem_resp_data : rd_word;
                  stall_d      = 1'b0;
                  state_d      = IDLE;
               end else begin
                  req_valid_d = 1'b1;
                  addr_d      = {tag, idx, cnt_nxt, 2'b00};
                  state_d     = FILL_REQ;
               end
            end
         end
         WR_REQ: begin
            if (mem_req_ready) begin
               req_valid_d = 1'b0;
               stall_d     = 1'b0;
               state_d     = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         valid_q     <= '0;
         stall_q     <= 1'b0;
         dout_q      <= '0;
         req_valid_q <= 1'b0;
         rnw_q       <= 1'b0;
         addr_q      <= '0;
         data_q      <= '0;
         mask_q      <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         valid_q     <= valid_d;
         stall_q     <= stall_d;
         dout_q      <= dout_d;
         req_valid_q <= req_valid_d;
         rnw_q       <= rnw_d;
         addr_q      <= addr_d;
         data_q      <= data_d;
         mask_q      <= mask_d;
      end
   end

   always_ff @(posedge clk) begin
      if (arr_we) data_mem[arr_ptr] <= arr_wdata;
      if (tag_we) tag_mem[idx] <= tag;
   end

   assign dcache_dout   = dout_q;
   assign stall         = stall_q;
   assign mem_req_valid = req_valid_q;
   assign mem_req_rnw   = rnw_q;
   assign mem_req_addr  = addr_q;
   assign mem_req_data  = data_q;
   assign mem_req_mask  = mask_q;

`ifdef DCACHE_STATS_EN
   logic        sampled;
   logic [31:0] hit_cnt_q, hit_cnt_d, miss_cnt_q, miss_cnt_d;

   always_comb begin
      sampled    = (state_q == IDLE) && ((dcache_we != 4'b0000) || dcache_re);
      hit_cnt_d  = hit_cnt_q + {31'b0, sampled && hit};
      miss_cnt_d = miss_cnt_q + {31'b0, sampled && !hit};
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hit_cnt_q  <= '0;
         miss_cnt_q <= '0;
      end else begin
         hit_cnt_q  <= hit_cnt_d;
         miss_cnt_q <= miss_cnt_d;
      end
   end

   assign hit_count  = hit_cnt_q;
   assign miss_count = miss_cnt_q;
`endif

endmodule

// File: tb/tb_dcache_responder.sv
// Bench for dcache_responder: directed vector table, multi-cycle corner sequences and random traffic
// checked against a line-level cache model and a reference memory image.
module tb_dcache_responder;

   localparam int LINES      = 64;
   localparam int LW         = 4;
   localparam int LINE_BYTES = LW * 4;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] dcache_addr;
   logic        dcache_re;
   logic [3:0]  dcache_we;
   logic [31:0] dcache_din;
   logic [31:0] dcache_dout;
   logic        stall;
   logic        mem_req_valid, mem_req_ready, mem_req_rnw;
   logic [31:0] mem_req_addr, mem_req_data;
   logic [3:0]  mem_req_mask;
   logic        mem_resp_valid;
   logic [31:0] mem_resp_data;
`ifdef DCACHE_STATS_EN
   logic [31:0] hit_count, miss_count;
`endif

   dcache_responder #(.LINES(LINES), .LINE_WORDS(LW)) dut (
      .clk(clk), .rst(rst),
      .dcache_addr(dcache_addr), .dcache_re(dcache_re), .dcache_we(dcache_we),
      .dcache_din(dcache_din), .dcache_dout(dcache_dout), .stall(stall),
      .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_rnw(mem_req_rnw),
      .mem_req_addr(mem_req_addr), .mem_req_data(mem_req_data), .mem_req_mask(mem_req_mask),
      .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data)
`ifdef DCACHE_STATS_EN
      , .hit_count(hit_count), .miss_count(miss_count)
`endif
   );

   // clock / reset
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   typedef struct {
      logic        rnw;
      logic [31:0] addr;
      logic [31:0] data;
      logic [3:0]  mask;
   } req_t;

   typedef struct {
      bit          wr;
      logic [31:0] addr;
      logic [3:0]  we;
      logic [31:0] din;
      bit          exp_hit;
      logic [31:0] exp_dout;
   } vec_t;

   req_t req_q[$];
   req_t exp_q[$];

   int checks = 0;
   int errors = 0;

   logic [31:0] back_mem [logic [31:0]];
   logic [31:0] ref_mem  [logic [31:0]];
   bit          m_valid [LINES];
   int unsigned m_tag   [LINES];
   logic [31:0] last_dout;
   int          n_hit, n_miss;

   int hold_cnt   = 0;
   int lat_fixed  = -1;
   bit ready_rand = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] init_word(input logic [31:0] a);
      if (a >= 32'h100 && a < 32'h110) return 32'hA0 + ((a - 32'h100) >> 2);
      return {a[15:0], ~a[15:0]};
   endfunction

   function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n, input logic [3:0] be);
      logic [31:0] r;
      r = o;
      for (int i = 0; i < 4; i++) if (be[i]) r[8*i +: 8] = n[8*i +: 8];
      return r;
   endfunction

   function automatic logic [31:0] back_read(input logic [31:0] a);
      return back_mem.exists(a) ? back_mem[a] : init_word(a);
   endfunction

   function automatic logic [31:0] ref_read(input logic [31:0] a);
      logic [31:0] w;
      w = {a[31:2], 2'b00};
      return ref_mem.exists(w) ? ref_mem[w] : init_word(w);
   endfunction

   function automatic bit model_hit(input logic [31:0] a);
      int unsigned li;
      li = (a / LINE_BYTES) % LINES;
      return m_valid[li] && (m_tag[li] == a / (LINE_BYTES * LINES));
   endfunction

   // backing memory: one read outstanding, in-order responses, posted writes, hold checks
   initial begin : mem_proc
      bit          rd_pend;
      int          lat;
      logic [31:0] rd_data;
      logic        pv, pr, prnw, prst;
      logic [31:0] pa, pd;
      logic [3:0]  pm;
      rd_pend = 1'b0; lat = 0; rd_data = '0;
      pv = 1'b0; pr = 1'b0; prnw = 1'b0; prst = 1'b1; pa = '0; pd = '0; pm = '0;
      mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_data = '0;
      forever begin
         @(negedge clk);
         mem_resp_valid = 1'b0;
         if (!rst && !prst && pv && !pr) begin
            chk("req_hold_valid", 32'(mem_req_valid), 32'd1);
            chk("req_hold_addr", mem_req_addr, pa);
            chk("req_hold_data", mem_req_data, pd);
            chk("req_hold_rnw_mask", {27'b0, mem_req_rnw, mem_req_mask}, {27'b0, prnw, pm});
         end
         if (rst) begin
            rd_pend = 1'b0;
            mem_req_ready = 1'b0;
         end else begin
            if (rd_pend) begin
               if (lat == 0) begin
                  mem_resp_valid = 1'b1;
                  mem_resp_data  = rd_data;
                  rd_pend        = 1'b0;
               end else lat--;
            end
            if (hold_cnt > 0) begin
               mem_req_ready = 1'b0;
               hold_cnt--;
            end else begin
               mem_req_ready = ready_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
            end
            if (mem_req_valid && mem_req_ready) begin
               req_q.push_back('{mem_req_rnw, mem_req_addr, mem_req_data, mem_req_mask});
               if (mem_req_rnw) begin
                  chk("one_outstanding", 32'(rd_pend), 32'd0);
                  rd_pend = 1'b1;
                  rd_data = back_read(mem_req_addr);
                  lat     = (lat_fixed >= 0) ? lat_fixed : $urandom_range(0, 2);
               end else begin
                  back_mem[mem_req_addr] = merge(back_read(mem_req_addr), mem_req_data, mem_req_mask);
               end
            end
         end
         pv = mem_req_valid; pr = mem_req_ready; prnw = mem_req_rnw;
         pa = mem_req_addr;  pd = mem_req_data;  pm = mem_req_mask; prst = rst;
      end
   end

   // driver: called at a negedge; holds the request until stall drops, then checks and updates the model
   task automatic do_op(input bit wr, input logic [31:0] a, input logic [3:0] we, input logic [31:0] din,
                        input bit exp_hit, input logic [31:0] exp_dout, input string name);
      int          cyc;
      int unsigned li;
      logic [31:0] a_al, line_base;
      a_al      = {a[31:2], 2'b00};
      line_base = (a_al / LINE_BYTES) * LINE_BYTES;
      req_q.delete();
      exp_q.delete();
      if (wr) exp_q.push_back('{1'b0, a_al, din, we});
      else if (!exp_hit) for (int i = 0; i < LW; i++) exp_q.push_back('{1'b1, line_base + 32'(4 * i), 32'h0, 4'h0});
      dcache_addr = a;
      dcache_din  = din;
      dcache_re   = !wr;
      dcache_we   = wr ? we : 4'b0000;
      @(negedge clk);
      if (!wr && exp_hit) begin
         chk({name, "_stall_hit"}, 32'(stall), 32'd0);
      end else begin
         chk({name, "_stall_rise"}, 32'(stall), 32'd1);
         cyc = 0;
         while (stall && cyc < 400) begin
            @(negedge clk);
            cyc++;
         end
         if (stall) chk({name, "_timeout"}, 32'(stall), 32'd0);
      end
      dcache_re = 1'b0;
      dcache_we = 4'b0000;
      chk({name, "_dout"}, dcache_dout, exp_dout);
      chk({name, "_nreq"}, 32'(req_q.size()), 32'(exp_q.size()));
      for (int i = 0; i < exp_q.size() && i < req_q.size(); i++) begin
         chk({name, "_req_addr"}, req_q[i].addr, exp_q[i].addr);
         chk({name, "_req_rnw"}, 32'(req_q[i].rnw), 32'(exp_q[i].rnw));
         if (!exp_q[i].rnw) begin
            chk({name, "_req_data"}, req_q[i].data, exp_q[i].data);
            chk({name, "_req_mask"}, 32'(req_q[i].mask), 32'(exp_q[i].mask));
         end
      end
      if (exp_hit) n_hit++; else n_miss++;
      if (wr) begin
         ref_mem[a_al] = merge(ref_read(a_al), din, we);
      end else if (!exp_hit) begin
         li          = (a_al / LINE_BYTES) % LINES;
         m_valid[li] = 1'b1;
         m_tag[li]   = a_al / (LINE_BYTES * LINES);
      end
      last_dout = exp_dout;
   endtask

   task automatic clear_model();
      for (int i = 0; i < LINES; i++) begin
         m_valid[i] = 1'b0;
         m_tag[i]   = 0;
      end
      last_dout = '0;
      n_hit     = 0;
      n_miss    = 0;
   endtask

   initial begin : main
      vec_t        vecs[12];
      int          cyc;
      bit          wr, eh;
      logic [31:0] a, din, ed;
      logic [3:0]  we;

      vecs[0]  = '{1'b0, 32'h100,  4'h0, 32'h0,        1'b0, 32'h000000A0};
      vecs[1]  = '{1'b0, 32'h108,  4'h0, 32'h0,        1'b1, 32'h000000A2};
      vecs[2]  = '{1'b1, 32'h104,  4'h1, 32'h000000FF, 1'b1, 32'h000000A2};
      vecs[3]  = '{1'b0, 32'h104,  4'h0, 32'h0,        1'b1, 32'h000000FF};
      vecs[4]  = '{1'b1, 32'h2000, 4'hF, 32'h12345678, 1'b0, 32'h000000FF};
      vecs[5]  = '{1'b0, 32'h2000, 4'h0, 32'h0,        1'b0, 32'h12345678};
      vecs[6]  = '{1'b0, 32'h500,  4'h0, 32'h0,        1'b0, 32'h0500FAFF};
      vecs[7]  = '{1'b0, 32'h100,  4'h0, 32'h0,        1'b0, 32'h000000A0};
      vecs[8]  = '{1'b0, 32'h10C,  4'h0, 32'h0,        1'b1, 32'h000000A3};
      vecs[9]  = '{1'b1, 32'h108,  4'hC, 32'hBEEF0000, 1'b1, 32'h000000A3};
      vecs[10] = '{1'b0, 32'h108,  4'h0, 32'h0,        1'b1, 32'hBEEF00A2};
      vecs[11] = '{1'b0, 32'h104,  4'h0, 32'h0,        1'b1, 32'h000000FF};

      clear_model();
      rst = 1'b1; dcache_addr = '0; dcache_re = 1'b0; dcache_we = 4'b0000; dcache_din = '0;
      repeat (3) @(negedge clk);
      chk("rst_stall", 32'(stall), 32'd0);
      chk("rst_req_valid", 32'(mem_req_valid), 32'd0);
      chk("rst_dout", dcache_dout, 32'd0);
`ifdef DCACHE_STATS_EN
      chk("rst_hit_count", hit_count, 32'd0);
      chk("rst_miss_count", miss_count, 32'd0);
`endif
      rst = 1'b0;
      @(negedge clk);
      chk("idle_stall", 32'(stall), 32'd0);

      for (int i = 0; i < 12; i++)
         do_op(vecs[i].wr, vecs[i].addr, vecs[i].we, vecs[i].din, vecs[i].exp_hit, vecs[i].exp_dout,
               $sformatf("vec%0d", i));

      // fill with ready held low for several cycles
      hold_cnt = 6;
      do_op(1'b0, 32'h708, 4'h0, 32'h0, model_hit(32'h708), ref_read(32'h708), "ready_low");

      // reset while a fill read is outstanding
      lat_fixed = 8;
      req_q.delete();
      dcache_addr = 32'h3000;
      dcache_re   = 1'b1;
      cyc = 0;
      while (req_q.size() == 0 && cyc < 50) begin
         @(negedge clk);
         cyc++;
      end
      chk("abort_req_seen", 32'(req_q.size()), 32'd1);
      @(negedge clk);
      rst = 1'b1;
      #1;
      chk("abort_stall", 32'(stall), 32'd0);
      chk("abort_req_valid", 32'(mem_req_valid), 32'd0);
      chk("abort_dout", dcache_dout, 32'd0);
      dcache_re = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      lat_fixed = -1;
      clear_model();
`ifdef DCACHE_STATS_EN
      chk("abort_hit_count", hit_count, 32'd0);
      chk("abort_miss_count", miss_count, 32'd0);
`endif
      @(negedge clk);
      do_op(1'b0, 32'h100, 4'h0, 32'h0, 1'b0, 32'h000000A0, "after_rst");

      // random traffic over a few conflicting tags and indices
      ready_rand = 1'b1;
      for (int n = 0; n < 150; n++) begin
         wr  = ($urandom_range(0, 9) < 3);
         a   = 32'($urandom_range(0, 2) * 1024 + $urandom_range(0, 3) * 16 +
                   $urandom_range(0, 3) * 4 + $urandom_range(0, 3));
         we  = 4'($urandom_range(1, 15));
         din = $urandom;
         eh  = model_hit(a);
         ed  = wr ? last_dout : ref_read(a);
         do_op(wr, a, we, din, eh, ed, $sformatf("rnd%0d", n));
      end

`ifdef DCACHE_STATS_EN
      chk("final_hit_count", hit_count, 32'(n_hit));
      chk("final_miss_count", miss_count, 32'(n_miss));
`endif
      repeat (2) @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
